frame_update_ctrl: RTL and testbench

- Frame-synchronous commit controller sitting between the game-logic FSM and the VGA display datapath.
- Game logic posts a complete scene update (snake body, fruits, poison, fruit type, game state) through a valid/ready handshake into a staging register.
- The block commits the staged scene to the display-facing outputs only at the start of vertical sync, so the display never shows a half-updated frame.
- It also generates the blink `flag` the display uses to flash the snake in game state 3'b010.

---
 rtl/frame_update_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_frame_update_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_ctrl.sv
// frame_update_ctrl: frame-synchronous scene commit controller.
// Game logic posts a full scene through a valid/ready handshake into a single
// staging register. The staged scene is copied to the display-facing outputs
// only on a vsync frame boundary, so the display never shows a torn frame.
// Also produces the snake blink flag used while the committed state is
// BLINK_STATE.
//
// Ports:
//   pclk, rst          pixel clock, synchronous active-high reset
//   vsync              vsync from the sync generator (pclk domain)
//   upd_valid/ready    scene update handshake
//   upd_*              scene update payload
//   *_o                committed scene
//   flag               snake visible when 1
//   commit             one-cycle pulse on the cycle the *_o outputs update
//   frame_cnt          frame boundaries since reset (wraps)
//   drop_cnt           saturating count of overwritten updates (optional)
//
// Build option: define FRAME_UPD_OVERWRITE_EN to tie upd_ready high and let a
// newer update overwrite a pending one (latest wins); adds drop_cnt.
module frame_update_ctrl #(
   parameter int unsigned BLINK_FRAMES     = 15,
   parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
   parameter logic [2:0]  BLINK_STATE      = 3'b010
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [39:0] upd_snake_x,
   input  logic [39:0] upd_snake_y,
   input  logic [3:0]  upd_nfruit_x,
   input  logic [3:0]  upd_nfruit_y,
   input  logic [3:0]  upd_ifruit_x,
   input  logic [3:0]  upd_ifruit_y,
   input  logic [3:0]  upd_poison_x,
   input  logic [3:0]  upd_poison_y,
   input  logic        upd_fruit,
   input  logic [2:0]  upd_state,
   output logic [39:0] snake_x_o,
   output logic [39:0] snake_y_o,
   output logic [3:0]  nfruit_x_o,
   output logic [3:0]  nfruit_y_o,
   output logic [3:0]  ifruit_x_o,
   output logic [3:0]  ifruit_y_o,
   output logic [3:0]  poison_x_o,
   output logic [3:0]  poison_y_o,
   output logic        fruit_o,
   output logic [2:0]  state_o,
   output logic        flag,
   output logic        commit,
`ifdef FRAME_UPD_OVERWRITE_EN
   output logic [7:0]  drop_cnt,
`endif
   output logic [15:0] frame_cnt
);

   localparam int unsigned SNAKE_W = 40;
   localparam int unsigned CELL_W  = 4;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned BLINK_W = 8;
   localparam int unsigned FRAME_W = 16;

   // vs_q resets to the inactive level so reset release alone is no boundary
   localparam logic               VS_IDLE    = 1'(VSYNC_ACTIVE_LOW);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [SNAKE_W-1:0] snake_x;
      logic [SNAKE_W-1:0] snake_y;
      logic [CELL_W-1:0]  nfruit_x;
      logic [CELL_W-1:0]  nfruit_y;
      logic [CELL_W-1:0]  ifruit_x;
      logic [CELL_W-1:0]  ifruit_y;
      logic [CELL_W-1:0]  poison_x;
      logic [CELL_W-1:0]  poison_y;
      logic               fruit;
      logic [STATE_W-1:0] state;
   } scene_t;

   typedef enum logic {S_EMPTY, S_FULL} stage_state_e;

   stage_state_e       state_q, state_d;
   scene_t             upd_s, stage_q, out_q;
   logic               vs_q;
   logic               fb_c, accept_c, commit_c;
   logic [BLINK_W-1:0] blink_cnt;

   assign upd_s = {upd_snake_x, upd_snake_y, upd_nfruit_x, upd_nfruit_y,
                   upd_ifruit_x, upd_ifruit_y, upd_poison_x, upd_poison_y,
                   upd_fruit, upd_state};

   assign {snake_x_o, snake_y_o, nfruit_x_o, nfruit_y_o, ifruit_x_o,
           ifruit_y_o, poison_x_o, poison_y_o, fruit_o, state_o} = out_q;

   // One-cycle frame boundary pulse on the active vsync edge
   assign fb_c = VSYNC_ACTIVE_LOW ? (vs_q & ~vsync) : (~vs_q & vsync);

`ifdef FRAME_UPD_OVERWRITE_EN
   logic drop_c;
`endif

   // Staging FSM: next state, capture and commit decisions
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      commit_c = 1'b0;
`ifdef FRAME_UPD_OVERWRITE_EN
      drop_c   = 1'b0;
`endif
      case (state_q)
         S_EMPTY: begin
            // a capture coincident with fb waits for the next boundary
            accept_c = upd_valid;
            if (upd_valid) state_d = S_FULL;
         end
         S_FULL: begin
            commit_c = fb_c;
`ifdef FRAME_UPD_OVERWRITE_EN
            // old stage commits on fb while new data lands in the stage
            accept_c = upd_valid;
            drop_c   = upd_valid & ~fb_c;
            if (fb_c & ~upd_valid) state_d = S_EMPTY;
`else
            if (fb_c) state_d = S_EMPTY;
`endif
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // State, stage, committed outputs and frame counter
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q   <= S_EMPTY;
         vs_q      <= VS_IDLE;
         stage_q   <= '0;
         out_q     <= '0;
         commit    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q <= state_d;
         vs_q    <= vsync;
         commit  <= commit_c;
         if (accept_c) stage_q <= upd_s;
         if (commit_c) out_q <= stage_q;
         if (fb_c) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

`ifdef FRAME_UPD_OVERWRITE_EN
   assign upd_ready = 1'b1;

   // Saturating count of updates that replaced a pending stage
   always_ff @(posedge pclk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_c && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   // Ready tracks the next stage state so it is valid right after each edge
   always_ff @(posedge pclk) begin
      if (rst) begin
         upd_ready <= 1'b1;
      end else begin
         upd_ready <= (state_d == S_EMPTY);
      end
   end
`endif

   // Blink: pinned visible outside BLINK_STATE, toggles every BLINK_FRAMES fb
   always_ff @(posedge pclk) begin
      if (rst) begin
         flag      <= 1'b1;
         blink_cnt <= '0;
      end else if (out_q.state != BLINK_STATE) begin
         flag      <= 1'b1;
         blink_cnt <= '0;
      end else if (fb_c) begin
         if (blink_cnt == BLINK_LAST) begin
            flag      <= ~flag;
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Bench for frame_update_ctrl: directed scene updates and vsync frames, with a
// queue-based scene model compared every cycle plus hand-computed pins.
module tb_frame_update_ctrl;

   localparam int unsigned BF       = 2;
   localparam logic [2:0]  BLINK_ST = 3'b010;
`ifdef FRAME_UPD_OVERWRITE_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   typedef struct packed {
      logic [39:0] sx;
      logic [39:0] sy;
      logic [3:0]  nx, ny, ix, iy, px, py;
      logic        fruit;
      logic [2:0]  st;
   } scene_t;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync = 1'b1;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   scene_t      upd = '0;
   logic [39:0] snake_x_o, snake_y_o;
   logic [3:0]  nfruit_x_o, nfruit_y_o, ifruit_x_o, ifruit_y_o, poison_x_o, poison_y_o;
   logic        fruit_o;
   logic [2:0]  state_o;
   logic        flag, commit;
   logic [15:0] frame_cnt;
`ifdef FRAME_UPD_OVERWRITE_EN
   logic [7:0]  drop_cnt;
`endif

   frame_update_ctrl #(.BLINK_FRAMES(BF), .VSYNC_ACTIVE_LOW(1'b1), .BLINK_STATE(BLINK_ST)) dut (
      .pclk(pclk), .rst(rst), .vsync(vsync),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_snake_x(upd.sx), .upd_snake_y(upd.sy),
      .upd_nfruit_x(upd.nx), .upd_nfruit_y(upd.ny),
      .upd_ifruit_x(upd.ix), .upd_ifruit_y(upd.iy),
      .upd_poison_x(upd.px), .upd_poison_y(upd.py),
      .upd_fruit(upd.fruit), .upd_state(upd.st),
      .snake_x_o(snake_x_o), .snake_y_o(snake_y_o),
      .nfruit_x_o(nfruit_x_o), .nfruit_y_o(nfruit_y_o),
      .ifruit_x_o(ifruit_x_o), .ifruit_y_o(ifruit_y_o),
      .poison_x_o(poison_x_o), .poison_y_o(poison_y_o),
      .fruit_o(fruit_o), .state_o(state_o),
      .flag(flag), .commit(commit),
`ifdef FRAME_UPD_OVERWRITE_EN
      .drop_cnt(drop_cnt),
`endif
      .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   scene_t dut_s;
   assign dut_s = {snake_x_o, snake_y_o, nfruit_x_o, nfruit_y_o, ifruit_x_o,
                   ifruit_y_o, poison_x_o, poison_y_o, fruit_o, state_o};

   int checks = 0;
   int errors = 0;
   int n_commit = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: at most one pending scene; committed on a vsync falling edge
   scene_t      pend[$];
   scene_t      m_out;
   logic        m_prev_vs, m_ready, m_commit, m_flag;
   logic [15:0] m_frames;
   int          m_fbs;
`ifdef FRAME_UPD_OVERWRITE_EN
   logic [7:0]  m_drop;
`endif

   always @(posedge pclk) begin
      logic fb, acc, was_blink;
      if (rst) begin
         pend.delete();
         m_out = '0; m_prev_vs = 1'b1; m_ready = 1'b1; m_commit = 1'b0;
         m_flag = 1'b1; m_frames = '0; m_fbs = 0;
`ifdef FRAME_UPD_OVERWRITE_EN
         m_drop = '0;
`endif
      end else begin
         fb        = m_prev_vs && !vsync;
         m_prev_vs = vsync;
         acc       = upd_valid && m_ready;
         was_blink = (m_out.st == BLINK_ST);
         m_commit  = 1'b0;
         if (fb) m_frames = m_frames + 16'd1;
         if (fb && pend.size() != 0) begin
            m_out    = pend.pop_front();
            m_commit = 1'b1;
         end
         if (acc) begin
            if (pend.size() != 0) begin
               pend.delete();
`ifdef FRAME_UPD_OVERWRITE_EN
               if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
`endif
            end
            pend.push_back(upd);
         end
         // flag = visible during even-numbered blink half-periods
         if (!was_blink) m_fbs = 0;
         else if (fb) m_fbs++;
         m_flag  = was_blink ? (((m_fbs / BF) % 2) == 0) : 1'b1;
         m_ready = OVR ? 1'b1 : (pend.size() == 0);
      end
   end

   always @(negedge pclk) begin
      if (chk_en) begin
         check("scene", 128'(dut_s), 128'(m_out));
         check("commit", 128'(commit), 128'(m_commit));
         check("flag", 128'(flag), 128'(m_flag));
         check("frame_cnt", 128'(frame_cnt), 128'(m_frames));
         check("upd_ready", 128'(upd_ready), 128'(m_ready));
`ifdef FRAME_UPD_OVERWRITE_EN
         check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
`endif
         if (commit) n_commit++;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // vsync falls; after this tick the boundary has been acted on
   task automatic fb_edge();
      vsync = 1'b0;
      tick();
   endtask

   task automatic fin_frame();
      repeat (2) tick();
      vsync = 1'b1;
      repeat (3) tick();
   endtask

   task automatic send(input logic [39:0] sx, input logic [2:0] st);
      upd = '{sx: sx, sy: ~sx, nx: sx[3:0], ny: 4'h5, ix: 4'h6, iy: sx[7:4],
              px: 4'h9, py: 4'hA, fruit: sx[0], st: st};
      upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
   endtask

   initial begin
      logic exp_flag [4];
      exp_flag = '{1'b1, 1'b0, 1'b0, 1'b1};
      rst = 1'b1;
      repeat (2) tick();
      chk_en = 1'b1;
      rst = 1'b0;
      check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
      check("rst_flag", 128'(flag), 128'd1);
      check("rst_ready", 128'(upd_ready), 128'd1);
      check("rst_state", 128'(state_o), 128'd0);

      // idle frames
      repeat (3) begin fb_edge(); fin_frame(); end
      check("idle_frame_cnt", 128'(frame_cnt), 128'd3);
      check("idle_commits", 128'(n_commit), 128'd0);
      check("idle_snake_x", 128'(snake_x_o), 128'd0);

`ifndef FRAME_UPD_OVERWRITE_EN
      // basic commit
      send(40'h0000000123, 3'b001);
      check("a_ready_low", 128'(upd_ready), 128'd0);
      check("a_hold", 128'(snake_x_o), 128'd0);
      repeat (2) tick();
      fb_edge();
      check("a_commit", 128'(commit), 128'd1);
      check("a_snake_x", 128'(snake_x_o), 128'h123);
      check("a_state", 128'(state_o), 128'd1);
      check("a_ready_back", 128'(upd_ready), 128'd1);
      fin_frame();
      check("a_commits", 128'(n_commit), 128'd1);

      // valid held while FULL is not captured until the stage drains
      send(40'h0000000456, 3'b011);
      upd = '{sx: 40'h789, sy: 40'h1, nx: 4'h1, ny: 4'h2, ix: 4'h3, iy: 4'h4,
              px: 4'h5, py: 4'h6, fruit: 1'b1, st: 3'b100};
      upd_valid = 1'b1;
      repeat (3) tick();
      check("c_blocked_state", 128'(state_o), 128'd1);
      fb_edge();
      check("b_snake_x", 128'(snake_x_o), 128'h456);
      tick();
      upd_valid = 1'b0;
      check("c_captured", 128'(upd_ready), 128'd0);
      fin_frame();
      fb_edge();
      check("c_snake_x", 128'(snake_x_o), 128'h789);
      check("c_state", 128'(state_o), 128'd4);
      fin_frame();

      // accept coincident with fb in EMPTY defers to the next frame
      upd = '{sx: 40'hABC, sy: 40'h2, nx: 4'h7, ny: 4'h8, ix: 4'h9, iy: 4'hA,
              px: 4'hB, py: 4'hC, fruit: 1'b0, st: 3'b001};
      upd_valid = 1'b1;
      fb_edge();
      upd_valid = 1'b0;
      check("d_no_commit", 128'(commit), 128'd0);
      check("d_hold", 128'(snake_x_o), 128'h789);
      fin_frame();
      fb_edge();
      check("d_commit", 128'(commit), 128'd1);
      check("d_snake_x", 128'(snake_x_o), 128'hABC);
      fin_frame();

      // blink with BF=2: 1 on entry, then 1,0,0,1 on successive fb
      send(40'h00000000E0, BLINK_ST);
      fb_edge();
      check("blink_entry", 128'(flag), 128'd1);
      fin_frame();
      for (int i = 0; i < 4; i++) begin
         fb_edge();
         check($sformatf("blink_fb%0d", i + 1), 128'(flag), 128'(exp_flag[i]));
         fin_frame();
      end
      send(40'h00000000F0, 3'b001);
      fb_edge();
      check("blink_exit", 128'(flag), 128'd1);
      fin_frame();
`else
      // three updates in one frame: latest wins, two drops
      send(40'h0000000111, 3'b001);
      send(40'h0000000222, 3'b001);
      send(40'h0000000333, 3'b011);
      check("ow_drop2", 128'(drop_cnt), 128'd2);
      fb_edge();
      check("ow_commit", 128'(commit), 128'd1);
      check("ow_snake_x", 128'(snake_x_o), 128'h333);
      fin_frame();

      // accept coincident with fb while FULL: old commits, new staged, no drop
      send(40'h0000000444, 3'b001);
      upd = '{sx: 40'h555, sy: 40'h3, nx: 4'h1, ny: 4'h1, ix: 4'h2, iy: 4'h2,
              px: 4'h3, py: 4'h3, fruit: 1'b1, st: 3'b100};
      upd_valid = 1'b1;
      fb_edge();
      upd_valid = 1'b0;
      check("ow_fb_snake_x", 128'(snake_x_o), 128'h444);
      check("ow_fb_drop", 128'(drop_cnt), 128'd2);
      fin_frame();
      fb_edge();
      check("ow_next_snake_x", 128'(snake_x_o), 128'h555);
      fin_frame();
`endif

      // reset mid-stage discards the pending update
      send(40'h0000000999, 3'b101);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_ready", 128'(upd_ready), 128'd1);
`ifdef FRAME_UPD_OVERWRITE_EN
      check("rst2_drop", 128'(drop_cnt), 128'd0);
`endif
      tick();
      fb_edge();
      check("rst2_no_commit", 128'(commit), 128'd0);
      check("rst2_state", 128'(state_o), 128'd0);
      fin_frame();
      check("rst2_frame_cnt", 128'(frame_cnt), 128'd1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
